// File: rtl/xgmii_pkg.sv
// Shared XGMII character codes, receive deframer state encoding and Ethernet CRC-32 helpers.
package xgmii_pkg;

   localparam logic [7:0] XGMII_START = 8'hFB;
   localparam logic [7:0] XGMII_TERM  = 8'hFD;
   localparam logic [7:0] XGMII_ERROR = 8'hFE;
   localparam logic [7:0] XGMII_IDLE  = 8'h07;
   localparam logic [7:0] PREAMBLE    = 8'h55;
   localparam logic [7:0] SFD         = 8'hD5;

   localparam logic [63:0] START_WORD = {SFD, {6{PREAMBLE}}, XGMII_START};

   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StTail,
      StDrop
   } rx_state_e;

   // Contiguous byte-valid mask covering lanes below k.
   function automatic logic [7:0] lane_mask(input logic [2:0] k);
      return (8'h01 << k) - 8'h01;
   endfunction

   // Reflected CRC-32, one bit at a time, skipping bytes whose keep bit is clear.
   function automatic logic [31:0] crc32_update(input logic [31:0] crc,
                                                input logic [63:0] data,
                                                input logic [7:0]  keep);
      logic [31:0] c;
      c = crc;
      for (int b = 0; b < 8; b++) begin
         if (keep[b]) begin
            for (int i = 0; i < 8; i++) begin
               c = (c >> 1) ^ ((c[0] ^ data[8*b+i]) ? CRC_POLY : 32'h0);
            end
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/xgmii_rx_deframer_if.sv
// Valid-qualified framed receive stream; master drives, slave consumes. No backpressure.
interface xgmii_rx_deframer_if;

   logic [63:0] rx_data;
   logic [7:0]  rx_keep;
   logic        rx_valid;
   logic        rx_sop;
   logic        rx_eop;
   logic        rx_err;

   modport master (
      output rx_data,
      output rx_keep,
      output rx_valid,
      output rx_sop,
      output rx_eop,
      output rx_err
   );

   modport slave (
      input rx_data,
      input rx_keep,
      input rx_valid,
      input rx_sop,
      input rx_eop,
      input rx_err
   );

endinterface

// File: rtl/xgmii_term_lane.sv
// Combinational Terminate locator: lowest lane carrying a control 0xFD, and whether the
// control mask is well formed around it (all lanes from k upward control, all below data).
module xgmii_term_lane
   import xgmii_pkg::*;
(
   input  logic [63:0] xgmii_d,
   input  logic [7:0]  xgmii_c,
   output logic        term_found,
   output logic [2:0]  term_lane,
   output logic        term_ok
);

   // Descending scan so the lowest matching lane is the one that sticks.
   always_comb begin
      term_found = 1'b0;
      term_lane  = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (xgmii_c[i] && (xgmii_d[8*i +: 8] == XGMII_TERM)) begin
            term_found = 1'b1;
            term_lane  = 3'(i);
         end
      end
   end

   assign term_ok = term_found && (xgmii_c == (8'hFF << term_lane));

endmodule

// File: rtl/xgmii_rx_deframer.sv
// XGMII RX deframer: strips start/preamble/SFD and Terminate, emits a framed stream via a
// one-word hold register. Define XGMII_RX_CRC_CHECK_EN to check the Ethernet FCS at eop.
module xgmii_rx_deframer
   import xgmii_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 190,
   parameter int unsigned CNT_W     = 32
) (
   input  logic                xgmii_rx_clk,
   input  logic                sys_rst,
   input  logic [63:0]         xgmii_rxd,
   input  logic [7:0]          xgmii_rxc,
   xgmii_rx_deframer_if.master rx,
   output logic [CNT_W-1:0]    frame_cnt,
   output logic [CNT_W-1:0]    err_cnt,
   output logic [CNT_W-1:0]    crc_err_cnt
);

   localparam int unsigned WordCntW = $clog2(MAX_WORDS + 1);

   rx_state_e            state_q;
   logic [63:0]          s_data_q;
   logic [7:0]           s_keep_q;
   logic                 s_sop_q;
   logic                 s_full_q;
   logic                 sop_pend_q;
   logic [WordCntW-1:0]  word_cnt_q;

   logic [63:0]          out_data_q;
   logic [7:0]           out_keep_q;
   logic                 out_valid_q;
   logic                 out_sop_q;
   logic                 out_eop_q;
   logic                 out_err_q;

   logic [CNT_W-1:0]     frame_cnt_q;
   logic [CNT_W-1:0]     err_cnt_q;

   logic                 is_data;
   logic                 is_start;
   logic                 start_ok;
   logic                 is_idle;
   logic                 term_found;
   logic [2:0]           term_lane;
   logic                 term_ok;
   logic                 eop_bad;

   xgmii_term_lane u_term_lane (
      .xgmii_d    (xgmii_rxd),
      .xgmii_c    (xgmii_rxc),
      .term_found (term_found),
      .term_lane  (term_lane),
      .term_ok    (term_ok)
   );

   assign is_data  = (xgmii_rxc == 8'h00);
   assign is_start = xgmii_rxc[0] && (xgmii_rxd[7:0] == XGMII_START);
   assign start_ok = (xgmii_rxc == 8'h01) && (xgmii_rxd == START_WORD);
   assign is_idle  = (xgmii_rxc == 8'hFF) && (xgmii_rxd[7:0] == XGMII_IDLE);

`ifdef XGMII_RX_CRC_CHECK_EN
   logic [31:0]      crc_q;
   logic [31:0]      crc_load;
   logic [7:0]       load_keep;
   logic [CNT_W-1:0] crc_err_cnt_q;

   // crc_q always covers every byte up to and including the word held in S.
   assign load_keep   = is_data ? 8'hFF : lane_mask(term_lane);
   assign crc_load    = crc32_update(sop_pend_q ? CRC_INIT : crc_q, xgmii_rxd, load_keep);
   assign eop_bad     = (crc_q != CRC_RESIDUE);
   assign crc_err_cnt = crc_err_cnt_q;
`else
   assign eop_bad     = 1'b0;
   assign crc_err_cnt = '0;
`endif

   always_ff @(posedge xgmii_rx_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= StIdle;
         s_data_q    <= '0;
         s_keep_q    <= '0;
         s_sop_q     <= 1'b0;
         s_full_q    <= 1'b0;
         sop_pend_q  <= 1'b0;
         word_cnt_q  <= '0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_err_q   <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
`ifdef XGMII_RX_CRC_CHECK_EN
         crc_q         <= CRC_INIT;
         crc_err_cnt_q <= '0;
`endif
      end else begin
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_err_q   <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q    <= StData;
                  sop_pend_q <= 1'b1;
                  word_cnt_q <= '0;
               end else if (is_start) begin
                  err_cnt_q <= err_cnt_q + CNT_W'(1);
               end
            end

            StData: begin
               if (is_data) begin
                  if (word_cnt_q == WordCntW'(MAX_WORDS)) begin
                     // Overlong frame: close what is held as a bad frame, drop the rest.
                     if (s_full_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= s_data_q;
                        out_keep_q  <= s_keep_q;
                        out_sop_q   <= s_sop_q;
                        out_eop_q   <= 1'b1;
                        out_err_q   <= 1'b1;
                     end
                     s_full_q  <= 1'b0;
                     err_cnt_q <= err_cnt_q + CNT_W'(1);
                     state_q   <= StDrop;
                  end else begin
                     if (s_full_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= s_data_q;
                        out_keep_q  <= s_keep_q;
                        out_sop_q   <= s_sop_q;
                     end
                     s_data_q   <= xgmii_rxd;
                     s_keep_q   <= 8'hFF;
                     s_sop_q    <= sop_pend_q;
                     s_full_q   <= 1'b1;
                     sop_pend_q <= 1'b0;
                     word_cnt_q <= word_cnt_q + WordCntW'(1);
`ifdef XGMII_RX_CRC_CHECK_EN
                     crc_q <= crc_load;
`endif
                  end
               end else if (term_ok) begin
                  if (term_lane == 3'd0) begin
                     if (s_full_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= s_data_q;
                        out_keep_q  <= 8'hFF;
                        out_sop_q   <= s_sop_q;
                        out_eop_q   <= 1'b1;
                        out_err_q   <= eop_bad;
                        if (eop_bad) begin
`ifdef XGMII_RX_CRC_CHECK_EN
                           crc_err_cnt_q <= crc_err_cnt_q + CNT_W'(1);
`endif
                        end else begin
                           frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end
                     end else begin
                        err_cnt_q <= err_cnt_q + CNT_W'(1);
                     end
                     s_full_q <= 1'b0;
                     state_q  <= StIdle;
                  end else begin
                     if (s_full_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= s_data_q;
                        out_keep_q  <= s_keep_q;
                        out_sop_q   <= s_sop_q;
                     end
                     s_data_q   <= xgmii_rxd;
                     s_keep_q   <= lane_mask(term_lane);
                     s_sop_q    <= sop_pend_q;
                     s_full_q   <= 1'b1;
                     sop_pend_q <= 1'b0;
                     state_q    <= StTail;
`ifdef XGMII_RX_CRC_CHECK_EN
                     crc_q <= crc_load;
`endif
                  end
               end else begin
                  // Error character, malformed control or an unexpected start.
                  if (s_full_q) begin
                     out_valid_q <= 1'b1;
                     out_data_q  <= s_data_q;
                     out_keep_q  <= s_keep_q;
                     out_sop_q   <= s_sop_q;
                     out_eop_q   <= 1'b1;
                     out_err_q   <= 1'b1;
                  end
                  s_full_q  <= 1'b0;
                  err_cnt_q <= err_cnt_q + CNT_W'(1);
                  if (start_ok) begin
                     state_q    <= StData;
                     sop_pend_q <= 1'b1;
                     word_cnt_q <= '0;
                  end else begin
                     state_q <= StDrop;
                  end
               end
            end

            StTail: begin
               out_valid_q <= 1'b1;
               out_data_q  <= s_data_q;
               out_keep_q  <= s_keep_q;
               out_sop_q   <= s_sop_q;
               out_eop_q   <= 1'b1;
               out_err_q   <= eop_bad;
               s_full_q    <= 1'b0;
               if (eop_bad) begin
`ifdef XGMII_RX_CRC_CHECK_EN
                  crc_err_cnt_q <= crc_err_cnt_q + CNT_W'(1);
`endif
               end else begin
                  frame_cnt_q <= frame_cnt_q + CNT_W'(1);
               end
               // A minimum-IFG start can arrive in this same cycle.
               if (start_ok) begin
                  state_q    <= StData;
                  sop_pend_q <= 1'b1;
                  word_cnt_q <= '0;
               end else begin
                  state_q <= StIdle;
                  if (is_start) begin
                     err_cnt_q <= err_cnt_q + CNT_W'(1);
                  end
               end
            end

            StDrop: begin
               if (start_ok) begin
                  state_q    <= StData;
                  sop_pend_q <= 1'b1;
                  word_cnt_q <= '0;
               end else if (term_found || is_idle) begin
                  state_q <= StIdle;
               end
            end

            default: state_q <= StIdle;
         endcase
      end
   end

   assign rx.rx_data  = out_data_q;
   assign rx.rx_keep  = out_keep_q;
   assign rx.rx_valid = out_valid_q;
   assign rx.rx_sop   = out_sop_q;
   assign rx.rx_eop   = out_eop_q;
   assign rx.rx_err   = out_err_q;

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Directed bench for xgmii_rx_deframer: a per-cycle vector table plus hand-written
// sequences for runt, overlong and mid-frame reset cases.
module tb_xgmii_rx_deframer;

   localparam int unsigned MaxWords = 190;

   localparam logic [63:0] START_W   = 64'hD555_5555_5555_55FB;
   localparam logic [63:0] BADSTRT_W = 64'hD455_5555_5555_55FB;
   localparam logic [63:0] IDLE_W    = 64'h0707_0707_0707_0707;
   localparam logic [63:0] TERM0_W   = 64'h0707_0707_0707_07FD;
   localparam logic [63:0] TERM5_W   = 64'h0707_FD11_2233_4455;
   localparam logic [63:0] TAIL_DATA = 64'h0000_0011_2233_4455;
   localparam logic [63:0] ERR_W     = 64'h1111_1111_FE11_1111;

   typedef struct {
      logic [7:0]  c;
      logic [63:0] d;
      logic        v;
      logic        sop;
      logic        eop;
      logic        err;
      logic [7:0]  keep;
      logic [63:0] data;
   } vec_t;

   logic        xgmii_rx_clk = 1'b0;
   logic        sys_rst;
   logic [63:0] xgmii_rxd;
   logic [7:0]  xgmii_rxc;
   logic [31:0] frame_cnt;
   logic [31:0] err_cnt;
   logic [31:0] crc_err_cnt;

   int n_vec = 0;
   int n_bad = 0;

   xgmii_rx_deframer_if rx_if ();

   xgmii_rx_deframer #(
      .MAX_WORDS (MaxWords),
      .CNT_W     (32)
   ) dut (
      .xgmii_rx_clk (xgmii_rx_clk),
      .sys_rst      (sys_rst),
      .xgmii_rxd    (xgmii_rxd),
      .xgmii_rxc    (xgmii_rxc),
      .rx           (rx_if),
      .frame_cnt    (frame_cnt),
      .err_cnt      (err_cnt),
      .crc_err_cnt  (crc_err_cnt)
   );

   always #5 xgmii_rx_clk = ~xgmii_rx_clk;

   function automatic logic [63:0] dw(input int f, input int n);
      return (64'(f) << 56) | 64'(n);
   endfunction

   function automatic vec_t mk(input logic [7:0] c, input logic [63:0] d, input logic v,
                               input logic sop, input logic eop, input logic err,
                               input logic [7:0] keep, input logic [63:0] data);
      vec_t r;
      r.c = c; r.d = d; r.v = v; r.sop = sop; r.eop = eop; r.err = err;
      r.keep = keep; r.data = data;
      return r;
   endfunction

   function automatic vec_t nil(input logic [7:0] c, input logic [63:0] d);
      return mk(c, d, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
   endfunction

   function automatic vec_t em(input logic [7:0] c, input logic [63:0] d, input logic sop,
                               input logic eop, input logic [63:0] data);
      return mk(c, d, 1'b1, sop, eop, 1'b0, 8'hFF, data);
   endfunction

   task automatic step(input logic [7:0] c, input logic [63:0] d);
      xgmii_rxc = c;
      xgmii_rxd = d;
      @(posedge xgmii_rx_clk);
      #1;
   endtask

   task automatic check_out(input string name, input vec_t e);
      logic [63:0] m;
      logic        bad;
      m = '0;
      for (int b = 0; b < 8; b++) if (e.keep[b]) m[8*b +: 8] = 8'hFF;
      if (!e.v) begin
         bad = rx_if.rx_valid | rx_if.rx_sop | rx_if.rx_eop | rx_if.rx_err;
      end else begin
         bad = !rx_if.rx_valid || (rx_if.rx_sop !== e.sop) || (rx_if.rx_eop !== e.eop) ||
               (rx_if.rx_err !== e.err) || (rx_if.rx_keep !== e.keep) ||
               ((rx_if.rx_data & m) !== (e.data & m));
      end
      n_vec++;
      if (bad) begin
         n_bad++;
         $display("FAIL %s: got v=%0b sop=%0b eop=%0b err=%0b keep=%02h data=%016h, want v=%0b sop=%0b eop=%0b err=%0b keep=%02h data=%016h",
                  name, rx_if.rx_valid, rx_if.rx_sop, rx_if.rx_eop, rx_if.rx_err,
                  rx_if.rx_keep, rx_if.rx_data, e.v, e.sop, e.eop, e.err, e.keep, e.data);
      end
   endtask

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      int   n_out;
      int   eop_at;
      logic eop_err;
      logic [63:0] eop_data;

      sys_rst   = 1'b1;
      xgmii_rxc = 8'hFF;
      xgmii_rxd = IDLE_W;
      repeat (2) @(posedge xgmii_rx_clk);
      #1;
      check_out("reset_out", nil(8'hFF, IDLE_W));
      check_val("reset_frame_cnt", 64'(frame_cnt), 64'd0);
      check_val("reset_err_cnt", 64'(err_cnt), 64'd0);
      sys_rst = 1'b0;

      // Frame 1: eight full words, terminate in lane 0.
      vecs.push_back(nil(8'hFF, IDLE_W));
      vecs.push_back(nil(8'h01, START_W));
      vecs.push_back(nil(8'h00, dw(0, 1)));
      for (int n = 2; n <= 8; n++) vecs.push_back(em(8'h00, dw(0, n), n == 2, 1'b0, dw(0, n - 1)));
      vecs.push_back(em(8'hFF, TERM0_W, 1'b0, 1'b1, dw(0, 8)));
      vecs.push_back(nil(8'hFF, IDLE_W));
      // Frame 2: seven words plus a 5-byte tail, next start arrives in the tail cycle.
      vecs.push_back(nil(8'h01, START_W));
      vecs.push_back(nil(8'h00, dw(2, 1)));
      for (int n = 2; n <= 7; n++) vecs.push_back(em(8'h00, dw(2, n), n == 2, 1'b0, dw(2, n - 1)));
      vecs.push_back(em(8'hE0, TERM5_W, 1'b0, 1'b0, dw(2, 7)));
      vecs.push_back(mk(8'h01, START_W, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1F, TAIL_DATA));
      vecs.push_back(nil(8'h00, dw(3, 1)));
      vecs.push_back(em(8'h00, dw(3, 2), 1'b1, 1'b0, dw(3, 1)));
      vecs.push_back(em(8'hFF, TERM0_W, 1'b0, 1'b1, dw(3, 2)));
      vecs.push_back(nil(8'hFF, IDLE_W));
      // Bad SFD: ignored apart from the error count.
      vecs.push_back(nil(8'h01, BADSTRT_W));
      vecs.push_back(nil(8'hFF, IDLE_W));
      // Error character in lane 3 mid-frame.
      vecs.push_back(nil(8'h01, START_W));
      vecs.push_back(nil(8'h00, dw(4, 1)));
      vecs.push_back(em(8'h00, dw(4, 2), 1'b1, 1'b0, dw(4, 1)));
      vecs.push_back(em(8'h00, dw(4, 3), 1'b0, 1'b0, dw(4, 2)));
      vecs.push_back(mk(8'h08, ERR_W, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, dw(4, 3)));
      vecs.push_back(nil(8'h00, dw(4, 9)));
      vecs.push_back(nil(8'hFF, IDLE_W));
      vecs.push_back(nil(8'h00, dw(4, 10)));

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].c, vecs[i].d);
         check_out($sformatf("row%0d", i), vecs[i]);
      end
      check_val("table_frame_cnt", 64'(frame_cnt), 64'd3);
      check_val("table_err_cnt", 64'(err_cnt), 64'd2);
      check_val("crc_err_cnt", 64'(crc_err_cnt), 64'd0);

      // Runt: start immediately followed by terminate.
      step(8'h01, START_W);
      check_out("runt_start", nil(8'h01, START_W));
      step(8'hFF, TERM0_W);
      check_out("runt_term", nil(8'hFF, TERM0_W));
      check_val("runt_err_cnt", 64'(err_cnt), 64'd3);

      // Overlong frame: MaxWords+5 data words.
      step(8'h01, START_W);
      n_out    = 0;
      eop_at   = -1;
      eop_err  = 1'b0;
      eop_data = '0;
      for (int n = 1; n <= int'(MaxWords) + 5; n++) begin
         step(8'h00, dw(5, n));
         if (rx_if.rx_valid) begin
            n_out++;
            if (rx_if.rx_eop && eop_at < 0) begin
               eop_at   = n;
               eop_err  = rx_if.rx_err;
               eop_data = rx_if.rx_data;
            end
         end
      end
      step(8'hFF, IDLE_W);
      if (rx_if.rx_valid) n_out++;
      check_val("long_words_out", 64'(n_out), 64'(MaxWords));
      check_val("long_eop_at", 64'(eop_at), 64'(MaxWords + 1));
      check_val("long_eop_err", 64'(eop_err), 64'd1);
      check_val("long_eop_data", eop_data, dw(5, int'(MaxWords)));
      check_val("long_err_cnt", 64'(err_cnt), 64'd4);

      // Normal frame after the overlong one.
      step(8'h01, START_W);
      check_out("post_start", nil(8'h01, START_W));
      step(8'h00, dw(6, 1));
      check_out("post_w1", nil(8'h00, dw(6, 1)));
      step(8'h00, dw(6, 2));
      check_out("post_w2", em(8'h00, dw(6, 2), 1'b1, 1'b0, dw(6, 1)));
      step(8'hFF, TERM0_W);
      check_out("post_term", em(8'hFF, TERM0_W, 1'b0, 1'b1, dw(6, 2)));
      check_val("post_frame_cnt", 64'(frame_cnt), 64'd4);

      // Reset in the middle of a frame.
      step(8'h01, START_W);
      step(8'h00, dw(7, 1));
      step(8'h00, dw(7, 2));
      check_out("mid_before_rst", em(8'h00, dw(7, 2), 1'b1, 1'b0, dw(7, 1)));
      #2;
      sys_rst = 1'b1;
      #1;
      check_out("mid_rst_out", nil(8'h00, dw(7, 2)));
      check_val("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
      check_val("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
      step(8'h00, dw(7, 3));
      sys_rst = 1'b0;
      step(8'h00, dw(7, 4));
      check_out("after_rst_data", nil(8'h00, dw(7, 4)));
      step(8'hFF, TERM0_W);
      check_out("after_rst_term", nil(8'hFF, TERM0_W));
      check_val("after_rst_frame_cnt", 64'(frame_cnt), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
